// File: rtl/pipeline_trace_buffer.sv
// pipeline_trace_buffer
//   Multi-channel trace recorder for the pipelined CPU. Each clock with a
//   qualified sample (probe_valid) it stores all probe channels plus a cycle
//   stamp into a circular buffer while armed. A masked compare on one channel
//   triggers the capture. Capture stops POST_TRIG samples after the trigger.
//   The recorded window is then streamed out oldest-first.
//
// Ports
//   clock        rising-edge system clock
//   reset        asynchronous, active-low reset
//   probe_in     NUM_CH channels, channel k = probe_in[k*CH_WIDTH +: CH_WIDTH]
//   probe_valid  sample qualifier (low = pipeline stalled, nothing captured)
//   arm          start a capture (only acted on in IDLE)
//   abort        return to IDLE from any state (beats arm and trigger)
//   trig_sel     channel used for the trigger compare
//   trig_value   trigger compare value
//   trig_mask    1 = bit takes part in the compare
//   rd_ready     readout consumer ready
//   rd_valid     rd_data / rd_cycle / rd_last are valid
//   rd_data      captured probes of the current readout entry
//   rd_cycle     cycle stamp of the current readout entry
//   rd_last      current readout entry is the final one
//   state        0 IDLE, 1 ARMED, 2 POST, 3 DONE
//   cycle_count  free-running cycle counter (also the stamp source)
//
// Readout handshake: an entry transfers on a clock edge where rd_valid and
// rd_ready are both high. While rd_valid is high and rd_ready is low, the
// rd_data, rd_cycle and rd_last outputs hold steady. rd_valid never drops
// without a transfer, except on abort or reset.

module pipeline_trace_buffer #(
    parameter int NUM_CH    = 4,
    parameter int CH_WIDTH  = 16,
    parameter int DEPTH     = 16,
    parameter int CYC_WIDTH = 16,
    parameter int POST_TRIG = 4
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [NUM_CH*CH_WIDTH-1:0]   probe_in,
    input  logic                         probe_valid,
    input  logic                         arm,
    input  logic                         abort,
    input  logic [$clog2(NUM_CH)-1:0]    trig_sel,
    input  logic [CH_WIDTH-1:0]          trig_value,
    input  logic [CH_WIDTH-1:0]          trig_mask,
    input  logic                         rd_ready,
    output logic                         rd_valid,
    output logic [NUM_CH*CH_WIDTH-1:0]   rd_data,
    output logic [CYC_WIDTH-1:0]         rd_cycle,
    output logic                         rd_last,
    output logic [1:0]                   state,
    output logic [CYC_WIDTH-1:0]         cycle_count
);

    localparam int PTR_W  = $clog2(DEPTH);
    localparam int FILL_W = PTR_W + 1;
    localparam int DATA_W = NUM_CH * CH_WIDTH;
    localparam int WORD_W = DATA_W + CYC_WIDTH;

    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(DEPTH);
    localparam logic [PTR_W-1:0]  POST_LIM = PTR_W'(POST_TRIG);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_POST  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t cur_state;
    state_t next_state;

    logic [WORD_W-1:0] mem [DEPTH];

    logic [PTR_W-1:0]  wr_ptr;
    logic [FILL_W-1:0] fill;
    logic [PTR_W-1:0]  post_cnt;
    logic [FILL_W-1:0] rd_cnt;     // entries already transferred out

    logic [CH_WIDTH-1:0] trig_ch;
    logic                trig_hit;
    logic                post_last;
    logic                capture;
    logic                start;
    logic                xfer;
    logic [PTR_W-1:0]    rd_ptr;
    logic [WORD_W-1:0]   rd_word;

    // Trigger channel mux.
    always_comb begin
        trig_ch = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (int'(trig_sel) == k) begin
                trig_ch = probe_in[k*CH_WIDTH +: CH_WIDTH];
            end
        end
    end

    assign trig_hit  = ((trig_ch & trig_mask) == (trig_value & trig_mask));
    assign post_last = ((post_cnt + 1'b1) == POST_LIM);
    assign capture   = probe_valid && !abort &&
                       ((cur_state == ST_ARMED) || (cur_state == ST_POST));
    assign start     = (cur_state == ST_IDLE) && arm && !abort;
    assign xfer      = rd_valid && rd_ready;

    // FSM state register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cur_state <= ST_IDLE;
        end else begin
            cur_state <= next_state;
        end
    end

    // FSM next-state logic.
    always_comb begin
        next_state = cur_state;
        if (abort) begin
            next_state = ST_IDLE;
        end else begin
            case (cur_state)
                ST_IDLE: begin
                    if (arm) next_state = ST_ARMED;
                end
                ST_ARMED: begin
                    if (probe_valid && trig_hit) begin
                        next_state = (POST_TRIG == 0) ? ST_DONE : ST_POST;
                    end
                end
                ST_POST: begin
                    if (probe_valid && post_last) next_state = ST_DONE;
                end
                ST_DONE: begin
                    if (xfer && rd_last) next_state = ST_IDLE;
                end
                default: next_state = ST_IDLE;
            endcase
        end
    end

    // Counters and pointers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cycle_count <= '0;
            wr_ptr      <= '0;
            fill        <= '0;
            post_cnt    <= '0;
            rd_cnt      <= '0;
        end else begin
            cycle_count <= cycle_count + 1'b1;
            if (start) begin
                fill     <= '0;
                post_cnt <= '0;
                rd_cnt   <= '0;
            end
            if (capture) begin
                wr_ptr <= wr_ptr + 1'b1;
                // Once full, the oldest entry is overwritten.
                if (fill != FILL_MAX) fill <= fill + 1'b1;
                if (cur_state == ST_POST) post_cnt <= post_cnt + 1'b1;
            end
            if (xfer) rd_cnt <= rd_cnt + 1'b1;
        end
    end

    // Trace storage; contents are meaningless until written, so there is no reset.
    always_ff @(posedge clock) begin
        if (capture) begin
            mem[wr_ptr] <= {probe_in, cycle_count};
        end
    end

    // The oldest entry sits at wr_ptr - fill. The low PTR_W bits of fill give
    // the right modular offset, including when the buffer is exactly full.
    assign rd_ptr  = wr_ptr - fill[PTR_W-1:0] + rd_cnt[PTR_W-1:0];
    assign rd_word = mem[rd_ptr];

    assign rd_valid = (cur_state == ST_DONE);
    assign rd_last  = rd_valid && (rd_cnt == (fill - 1'b1));
    assign rd_data  = rd_valid ? rd_word[WORD_W-1:CYC_WIDTH] : '0;
    assign rd_cycle = rd_valid ? rd_word[CYC_WIDTH-1:0] : '0;
    assign state    = cur_state;

endmodule

// File: tb/tb_pipeline_trace_buffer.sv
// tb_pipeline_trace_buffer
//   Directed and random checks of pipeline_trace_buffer against a queue-based
//   reference model. A second instance with a 4-bit cycle stamp shares every
//   input, so stamp wrap-around is observed alongside the main instance.

module tb_pipeline_trace_buffer;

    localparam int NUM_CH    = 4;
    localparam int CH_WIDTH  = 16;
    localparam int DEPTH     = 16;
    localparam int POST_TRIG = 4;
    localparam int DW        = NUM_CH * CH_WIDTH;

    // ---------------- clock / reset ----------------
    logic clock;
    logic reset;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // ---------------- DUT signals ----------------
    logic [DW-1:0]       probe_in;
    logic                probe_valid;
    logic                arm;
    logic                abort;
    logic [1:0]          trig_sel;
    logic [CH_WIDTH-1:0] trig_value;
    logic [CH_WIDTH-1:0] trig_mask;
    logic                rd_ready;

    logic                rd_valid,  rd_valid4;
    logic [DW-1:0]       rd_data,   rd_data4;
    logic [15:0]         rd_cycle;
    logic [3:0]          rd_cycle4;
    logic                rd_last,   rd_last4;
    logic [1:0]          state,     state4;
    logic [15:0]         cycle_count;
    logic [3:0]          cycle_count4;

    pipeline_trace_buffer #(
        .NUM_CH(NUM_CH), .CH_WIDTH(CH_WIDTH), .DEPTH(DEPTH),
        .CYC_WIDTH(16), .POST_TRIG(POST_TRIG)
    ) u_dut (
        .clock(clock), .reset(reset), .probe_in(probe_in), .probe_valid(probe_valid),
        .arm(arm), .abort(abort), .trig_sel(trig_sel), .trig_value(trig_value),
        .trig_mask(trig_mask), .rd_ready(rd_ready), .rd_valid(rd_valid),
        .rd_data(rd_data), .rd_cycle(rd_cycle), .rd_last(rd_last),
        .state(state), .cycle_count(cycle_count)
    );

    pipeline_trace_buffer #(
        .NUM_CH(NUM_CH), .CH_WIDTH(CH_WIDTH), .DEPTH(DEPTH),
        .CYC_WIDTH(4), .POST_TRIG(POST_TRIG)
    ) u_dut4 (
        .clock(clock), .reset(reset), .probe_in(probe_in), .probe_valid(probe_valid),
        .arm(arm), .abort(abort), .trig_sel(trig_sel), .trig_value(trig_value),
        .trig_mask(trig_mask), .rd_ready(rd_ready), .rd_valid(rd_valid4),
        .rd_data(rd_data4), .rd_cycle(rd_cycle4), .rd_last(rd_last4),
        .state(state4), .cycle_count(cycle_count4)
    );

    // ---------------- reference model ----------------
    // Mode: 0 idle, 1 waiting for trigger, 2 post-trigger, 3 reading out.
    typedef struct {
        logic [DW-1:0] data;
        int            stamp;
    } ent_t;

    ent_t exp_q[$];
    int   m_mode;
    int   m_cyc;
    int   m_post;

    int   n_cmp;
    int   n_err;

    int   rec_ch[$];
    int   rec_cy[$];
    int   rec_last[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Applies the capture rules to the inputs about to be clocked in.
    task automatic model_edge();
        logic [CH_WIDTH-1:0] ch;
        ch = probe_in[trig_sel*CH_WIDTH +: CH_WIDTH];
        if (abort) begin
            m_mode = 0;
        end else begin
            case (m_mode)
                0: if (arm) begin
                    m_mode = 1;
                    m_post = 0;
                    exp_q.delete();
                end
                1, 2: if (probe_valid) begin
                    exp_q.push_back('{probe_in, m_cyc});
                    if (exp_q.size() > DEPTH) void'(exp_q.pop_front());
                    if (m_mode == 1) begin
                        if ((ch & trig_mask) == (trig_value & trig_mask))
                            m_mode = (POST_TRIG == 0) ? 3 : 2;
                    end else begin
                        m_post++;
                        if (m_post == POST_TRIG) m_mode = 3;
                    end
                end
                default: if (rd_ready) begin
                    void'(exp_q.pop_front());
                    if (exp_q.size() == 0) m_mode = 0;
                end
            endcase
        end
        m_cyc++;
    endtask

    task automatic check_cycle();
        chk("state", 64'(state), 64'(m_mode));
        chk("state4", 64'(state4), 64'(m_mode));
        chk("rd_valid", 64'(rd_valid), 64'(m_mode == 3));
        chk("rd_valid4", 64'(rd_valid4), 64'(m_mode == 3));
        chk("cycle_count", 64'(cycle_count), 64'(m_cyc[15:0]));
        chk("cycle_count4", 64'(cycle_count4), 64'(m_cyc[3:0]));
        if (m_mode == 3) begin
            chk("rd_data", rd_data, exp_q[0].data);
            chk("rd_data4", rd_data4, exp_q[0].data);
            chk("rd_cycle", 64'(rd_cycle), 64'(exp_q[0].stamp[15:0]));
            chk("rd_cycle4", 64'(rd_cycle4), 64'(exp_q[0].stamp[3:0]));
            chk("rd_last", 64'(rd_last), 64'(exp_q.size() == 1));
            chk("rd_last4", 64'(rd_last4), 64'(exp_q.size() == 1));
        end else begin
            chk("rd_last_idle", 64'(rd_last), 64'd0);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        model_edge();
        @(posedge clock);
        #1;
        check_cycle();
    endtask

    task automatic set_probe(input logic [15:0] ch0);
        probe_in = {16'($urandom), 16'($urandom), 16'($urandom), ch0};
    endtask

    task automatic set_trig(input logic [1:0] sel, input logic [15:0] val, input logic [15:0] msk);
        trig_sel   = sel;
        trig_value = val;
        trig_mask  = msk;
    endtask

    task automatic arm_dut();
        arm = 1'b1;
        set_probe(16'hFFFF);
        tick();
        arm = 1'b0;
    endtask

    // vmode: 0 always valid, 1 valid on alternate cycles, 2 random valid.
    task automatic run_capture(input int vmode, input bit rand_ch, input int k0);
        int  k;
        int  guard;
        bit  v;
        k = k0;
        guard = 0;
        while ((m_mode == 1 || m_mode == 2) && guard < 300) begin
            case (vmode)
                0:       v = 1'b1;
                1:       v = (guard % 2 == 0);
                default: v = 1'($urandom_range(0, 1));
            endcase
            probe_valid = v;
            set_probe((v && !rand_ch) ? 16'(k) : 16'($urandom));
            if (v) k++;
            tick();
            guard++;
        end
        probe_valid = 1'b0;
        chk("capture_done", 64'(state), 64'd3);
    endtask

    task automatic readout(input bit rand_ready);
        int guard;
        guard = 0;
        rec_ch.delete();
        rec_cy.delete();
        rec_last.delete();
        while (m_mode == 3 && guard < 300) begin
            rd_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            if (rd_ready) begin
                rec_ch.push_back(int'(rd_data[15:0]));
                rec_cy.push_back(int'(rd_cycle));
                rec_last.push_back(int'(rd_last));
            end
            tick();
            guard++;
        end
        rd_ready = 1'b0;
        chk("readout_idle", 64'(state), 64'd0);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    logic [DW-1:0] h_data;
    logic [15:0]   h_cyc;

    initial begin
        n_cmp = 0; n_err = 0;
        m_mode = 0; m_cyc = 0; m_post = 0;
        reset = 1'b0;
        probe_in = '0; probe_valid = 1'b0; arm = 1'b0; abort = 1'b0;
        rd_ready = 1'b0;
        set_trig(2'd0, 16'd0, 16'hFFFF);

        // Reset state.
        repeat (2) @(posedge clock);
        #1;
        check_cycle();
        chk("reset_rd_data", rd_data, 64'd0);
        chk("reset_rd_cycle", 64'(rd_cycle), 64'd0);
        reset = 1'b1;

        // 1: full window, trigger ch0 == 20.
        set_trig(2'd0, 16'd20, 16'hFFFF);
        arm_dut();
        run_capture(0, 1'b0, 0);
        readout(1'b0);
        chk("t1_count", 64'(rec_ch.size()), 64'd16);
        chk("t1_first", 64'(rec_ch[0]), 64'd9);
        chk("t1_trig_entry", 64'(rec_ch[11]), 64'd20);
        chk("t1_final", 64'(rec_ch[15]), 64'd24);
        chk("t1_last_flag", 64'(rec_last[15]), 64'd1);
        chk("t1_not_last", 64'(rec_last[14]), 64'd0);
        for (int i = 1; i < rec_cy.size(); i++)
            chk("t1_stamp_step", 64'((rec_cy[i] - rec_cy[i-1]) & 16'hFFFF), 64'd1);

        // 2: early trigger on the third sample.
        set_trig(2'd0, 16'd2, 16'hFFFF);
        arm_dut();
        run_capture(0, 1'b0, 0);
        readout(1'b0);
        chk("t2_count", 64'(rec_ch.size()), 64'd7);
        chk("t2_first", 64'(rec_ch[0]), 64'd0);
        chk("t2_final", 64'(rec_ch[6]), 64'd6);

        // 3: probe_valid toggling.
        set_trig(2'd0, 16'd3, 16'hFFFF);
        arm_dut();
        run_capture(1, 1'b0, 0);
        readout(1'b0);
        chk("t3_count", 64'(rec_ch.size()), 64'd8);
        for (int i = 0; i < rec_ch.size(); i++)
            chk("t3_ch0", 64'(rec_ch[i]), 64'(i));
        for (int i = 1; i < rec_cy.size(); i++)
            chk("t3_stamp_step", 64'((rec_cy[i] - rec_cy[i-1]) & 16'hFFFF), 64'd2);

        // 4: backpressure in DONE.
        set_trig(2'd0, 16'd5, 16'hFFFF);
        arm_dut();
        run_capture(0, 1'b0, 0);
        h_data = rd_data;
        h_cyc  = rd_cycle;
        rd_ready = 1'b0;
        repeat (5) begin
            tick();
            chk("t4_valid_held", 64'(rd_valid), 64'd1);
            chk("t4_data_held", rd_data, h_data);
            chk("t4_cycle_held", 64'(rd_cycle), 64'(h_cyc));
        end
        readout(1'b0);
        chk("t4_count", 64'(rec_ch.size()), 64'd10);
        chk("t4_first", 64'(rec_ch[0]), 64'd0);

        // 5a: abort in POST, then abort beats arm in IDLE.
        set_trig(2'd0, 16'd2, 16'hFFFF);
        arm_dut();
        probe_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            set_probe(16'(k));
            tick();
        end
        chk("t5_in_post", 64'(state), 64'd2);
        abort = 1'b1;
        tick();
        chk("t5_abort_idle", 64'(state), 64'd0);
        arm = 1'b1;
        tick();
        chk("t5_abort_over_arm", 64'(state), 64'd0);
        abort = 1'b0; arm = 1'b0; rd_ready = 1'b1;
        repeat (4) tick();
        rd_ready = 1'b0; probe_valid = 1'b0;

        // 5b: arm while ARMED keeps earlier samples.
        set_trig(2'd0, 16'd4, 16'hFFFF);
        arm_dut();
        probe_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            set_probe(16'(k));
            tick();
        end
        arm = 1'b1;
        set_probe(16'd3);
        tick();
        arm = 1'b0;
        run_capture(0, 1'b0, 4);
        readout(1'b0);
        chk("t5b_count", 64'(rec_ch.size()), 64'd9);
        chk("t5b_first", 64'(rec_ch[0]), 64'd0);

        // 6: reset mid-POST, then stamp wrap on the 4-bit instance.
        set_trig(2'd0, 16'd1, 16'hFFFF);
        arm_dut();
        probe_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            set_probe(16'(k));
            tick();
        end
        probe_valid = 1'b0;
        reset = 1'b0;
        #2;
        chk("t6_state", 64'(state), 64'd0);
        chk("t6_cycle_count", 64'(cycle_count), 64'd0);
        chk("t6_rd_valid", 64'(rd_valid), 64'd0);
        m_mode = 0; m_cyc = 0; exp_q.delete();
        @(posedge clock);
        #1;
        check_cycle();
        reset = 1'b1;
        repeat (16) tick();
        chk("t6_wrap4", 64'(cycle_count4), 64'd0);
        chk("t6_count16", 64'(cycle_count), 64'd16);

        // Random rounds: random channel, loose mask, random valid and ready.
        for (int r = 0; r < 8; r++) begin
            set_trig(2'($urandom_range(0, 3)), 16'($urandom), 16'h0007);
            arm_dut();
            run_capture(2, 1'b1, 0);
            readout(1'b1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
